// File: rtl/load_unit_pkg.sv
// Shared load/store definitions: funct3 encodings and FSM state encodings.
// The future store unit imports this package as well.
package load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // True when the request can never be issued: bad funct3 or misaligned access.
    function automatic logic load_rejected(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic rej;
        case (funct3)
            F3_LB, F3_LBU: rej = 1'b0;
            F3_LH, F3_LHU: rej = addr_lo[0];
            F3_LW:         rej = |addr_lo;
            default:       rej = 1'b1;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/load_unit_align.sv
// Combinational lane extraction and sign/zero extension of a little-endian read word.
module load_align
    import load_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_lanes [4];
    logic [15:0] half_lanes [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lanes[gi] = data[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lanes[gi] = data[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = byte_lanes[lane];
    assign half_sel = half_lanes[lane[1]];

    always_comb begin
        value = data;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = data;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load-path stage: one outstanding word-aligned memory read, extracted and extended
// result presented with a single-cycle load_valid pulse (drives the data register enable).
module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        load_fault,
    output logic        busy
);

    state_t             state_reg, state_next;
    logic [31:0]        addr_reg;
    logic [2:0]         funct3_reg;
    logic [TMO_W-1:0]   cnt_reg;
    logic [31:0]        load_data_reg;
    logic [31:0]        aligned_value;
    logic               timeout_hit;

    load_align u_align (
        .data   (mem_rsp_data),
        .lane   (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .value  (aligned_value)
    );

    // Counter value TIMEOUT_CYCLES-1 means this is the last permitted WAIT cycle.
    assign timeout_hit = (cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            funct3_reg    <= '0;
            cnt_reg       <= '0;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
            end
            if (state_reg == ST_REQ) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg + TMO_W'(1);
            end
            if (state_reg == ST_WAIT && mem_rsp_valid) begin
                load_data_reg <= aligned_value;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = load_rejected(req_funct3, req_addr[1:0]) ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the timeout cycle still completes the load.
                if (mem_rsp_valid)    state_next = ST_DONE;
                else if (timeout_hit) state_next = ST_FAULT;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign req_ready     = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign mem_req_valid = (state_reg == ST_REQ);
    assign mem_addr      = {addr_reg[31:2], 2'b00};
    assign load_valid    = (state_reg == ST_DONE);
    assign load_fault    = (state_reg == ST_FAULT);
    assign load_data     = load_data_reg;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: alignment/extension, faults, stall, timeout, reset.
module tb_load_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    load_unit #(.TIMEOUT_CYCLES(255), .TMO_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .load_fault    (load_fault),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one request from a negedge; cycle 0 is the request cycle. Memory grants
    // after hold_ready cycles and answers one cycle after the handshake when give_rsp.
    // junk_rsp drives stray responses during REQ stall cycles and on the handshake cycle.
    task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rsp,
                            input int hold_ready, input bit give_rsp, input bit junk_rsp,
                            input int ncyc, output int vcyc, output int fcyc, output int nreq,
                            output logic [31:0] mem_a, output bit unstable, output int nbusy);
        bit pend, junk;
        vcyc = -1; fcyc = -1; nreq = 0; mem_a = '0; unstable = 0; nbusy = 0;
        pend = 0; junk = 0;
        req_addr = a; req_funct3 = f3; req_valid = 1'b1; mem_req_ready = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock); #1;
            req_valid     = 1'b0;
            mem_req_ready = (c > hold_ready);
            mem_rsp_valid = pend | junk;
            mem_rsp_data  = pend ? rsp : 32'h5A5A_5A5A;
            pend = 0; junk = 0;
            @(negedge clock);
            if (load_valid && vcyc < 0) vcyc = c;
            if (load_fault && fcyc < 0) fcyc = c;
            if (busy) nbusy++;
            if (busy == req_ready) unstable = 1;
            if (mem_req_valid) begin
                if (nreq == 0) mem_a = mem_addr;
                else if (mem_addr !== mem_a) unstable = 1;
                nreq++;
                if (mem_req_ready) pend = give_rsp;
                else junk = junk_rsp;
                if (junk_rsp && mem_req_ready) junk = 1;
            end
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 0; req_addr = '0; req_funct3 = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 1'b0 || load_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b lv=%b lf=%b want rdy=1 busy=0 lv=0 lf=0",
                     req_ready, busy, load_valid, load_fault);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got mrv=%b maddr=%h data=%h want 0/0/0", mem_req_valid, mem_addr, load_data);
        end
        reset = 1'b1;
        @(negedge clock);
        $display("reset: rdy=%b busy=%b data=%h", req_ready, busy, load_data);
    endtask

    task automatic test_lw();
        int v, f, n, nb; logic [31:0] ma; bit un;
        run_load(32'h100, 3'd2, 32'hDEAD_BEEF, 0, 1, 0, 6, v, f, n, ma, un, nb);
        $display("LW 0x100 rsp DEADBEEF: vcyc=%0d maddr=%h data=%h", v, ma, load_data);
        checks++;
        if (v !== 3 || f !== -1) begin errors++; $display("FAIL lw_latency got v=%0d f=%0d want v=3 f=-1", v, f); end
        checks++;
        if (ma !== 32'h100 || n !== 1) begin errors++; $display("FAIL lw_memaddr got %h n=%0d want 00000100 n=1", ma, n); end
        checks++;
        if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", load_data); end
        checks++;
        if (nb !== 3 || un) begin errors++; $display("FAIL lw_busy got nbusy=%0d bad=%b want 3 0", nb, un); end
    endtask

    task automatic test_extend();
        logic [31:0] a_tab [6] = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h100, 32'h102};
        logic [2:0]  f_tab [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd5};
        logic [31:0] r_tab [6] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233,
                                   32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
        logic [31:0] e_tab [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0022,
                                   32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_8001};
        for (int i = 0; i < 6; i++) begin
            int v, f, n, nb; logic [31:0] ma; bit un;
            run_load(a_tab[i], f_tab[i], r_tab[i], 0, 1, 0, 5, v, f, n, ma, un, nb);
            $display("ext f3=%0d addr=%h rsp=%h: data=%h vcyc=%0d maddr=%h", f_tab[i], a_tab[i], r_tab[i], load_data, v, ma);
            checks++;
            if (load_data !== e_tab[i] || v !== 3 || ma !== 32'h100) begin
                errors++;
                $display("FAIL extend_%0d got data=%h v=%0d maddr=%h want data=%h v=3 maddr=00000100",
                         i, load_data, v, ma, e_tab[i]);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] a_tab [5] = '{32'h101, 32'h100, 32'h103, 32'h100, 32'h102};
        logic [2:0]  f_tab [5] = '{3'd2, 3'd3, 3'd1, 3'd6, 3'd2};
        // load_data before this test: last extend case leaves 0x00008001
        for (int i = 0; i < 5; i++) begin
            int v, f, n, nb; logic [31:0] ma; bit un;
            run_load(a_tab[i], f_tab[i], 32'h1111_1111, 0, 1, 0, 4, v, f, n, ma, un, nb);
            $display("fault f3=%0d addr=%h: fcyc=%0d nreq=%0d data=%h", f_tab[i], a_tab[i], f, n, load_data);
            checks++;
            if (f !== 1 || v !== -1 || n !== 0 || nb !== 1 || load_data !== 32'h0000_8001) begin
                errors++;
                $display("FAIL fault_%0d got f=%0d v=%0d nreq=%0d nbusy=%0d data=%h want f=1 v=-1 nreq=0 nbusy=1 data=00008001",
                         i, f, v, n, nb, load_data);
            end
        end
    endtask

    task automatic test_stall();
        int v, f, n, nb; logic [31:0] ma; bit un;
        run_load(32'h0000_2346, 3'd1, 32'hC0DE_0000, 5, 1, 1, 10, v, f, n, ma, un, nb);
        $display("stall LH 0x2346: nreq=%0d maddr=%h unstable=%b vcyc=%0d data=%h", n, ma, un, v, load_data);
        checks++;
        if (n !== 6 || ma !== 32'h0000_2344 || un) begin
            errors++;
            $display("FAIL stall_hold got nreq=%0d maddr=%h unstable=%b want 6 00002344 0", n, ma, un);
        end
        checks++;
        if (v !== 8 || load_data !== 32'hFFFF_C0DE) begin
            errors++;
            $display("FAIL stall_data got v=%0d data=%h want v=8 data=ffffc0de", v, load_data);
        end
    endtask

    task automatic test_timeout();
        int v, f, n, nb; logic [31:0] ma; bit un;
        int late_valid;
        run_load(32'h200, 3'd2, 32'h0, 0, 0, 0, 258, v, f, n, ma, un, nb);
        $display("timeout LW 0x200: fcyc=%0d vcyc=%0d busy=%b", f, v, busy);
        checks++;
        if (f !== 257 || v !== -1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout got f=%0d v=%0d busy=%b want f=257 v=-1 busy=0", f, v, busy);
        end
        late_valid = 0;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        repeat (3) begin @(negedge clock); if (load_valid || busy) late_valid++; end
        $display("late rsp after timeout: events=%0d data=%h", late_valid, load_data);
        checks++;
        if (late_valid !== 0 || load_data !== 32'hFFFF_C0DE) begin
            errors++;
            $display("FAIL late_rsp got events=%0d data=%h want 0 ffffc0de", late_valid, load_data);
        end
    endtask

    task automatic test_back_to_back();
        int v1, f1, n1, nb1, v2, f2, n2, nb2; logic [31:0] ma1, ma2; bit un1, un2;
        logic [31:0] d1;
        run_load(32'h400, 3'd4, 32'hAABB_CCDD, 0, 1, 0, 4, v1, f1, n1, ma1, un1, nb1);
        d1 = load_data;
        run_load(32'h406, 3'd5, 32'h1234_5678, 0, 1, 0, 4, v2, f2, n2, ma2, un2, nb2);
        $display("b2b: d1=%h v1=%0d d2=%h v2=%0d maddr2=%h", d1, v1, load_data, v2, ma2);
        checks++;
        if (d1 !== 32'h0000_00DD || v1 !== 3) begin errors++; $display("FAIL b2b_first got %h v=%0d want 000000dd v=3", d1, v1); end
        checks++;
        if (load_data !== 32'h0000_1234 || v2 !== 3 || ma2 !== 32'h404) begin
            errors++;
            $display("FAIL b2b_second got %h v=%0d maddr=%h want 00001234 v=3 00000404", load_data, v2, ma2);
        end
    endtask

    task automatic test_reset_mid();
        int events;
        req_addr = 32'h500; req_funct3 = 3'd2; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got busy=%b mrv=%b want 1 0", busy, mem_req_valid);
        end
        #1 reset = 1'b0;
        #1;
        $display("reset in WAIT: busy=%b rdy=%b data=%h", busy, req_ready, load_data);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || load_data !== 32'h0 || load_valid !== 1'b0 || load_fault !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b rdy=%b data=%h lv=%b lf=%b want 0 1 0 0 0",
                     busy, req_ready, load_data, load_valid, load_fault);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h9999_9999;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        events = 0;
        repeat (3) begin @(negedge clock); if (load_valid || load_fault || busy) events++; end
        $display("rsp after reset release: events=%0d data=%h", events, load_data);
        checks++;
        if (events !== 0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_rsp got events=%0d data=%h want 0 00000000", events, load_data);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_extend();
        test_fault();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
